// File: rtl/freq_sweep_ctrl_if.sv
// Bundle of the controller's link, algorithm and NCO signals.
// Latency: n/a (wires only).
// Backpressure: none; freqAlgGo/freqAlgDone form a level/edge handshake with the algorithm.
//
// master : drives link qualifier and algorithm results, observes tuning word/status
// slave  : the sweep controller itself
interface freq_sweep_ctrl_if;
    logic        swiptAlive;   // link-up qualifier
    logic        freqAlgDone;  // sweep-finished flag from the algorithm
    logic [19:0] newFreq;      // trial frequency requested by the algorithm
    logic [19:0] bestFreq;     // best frequency found by the algorithm
    logic [19:0] freq;         // applied tuning word, fed back to the algorithm
    logic        freqAlgGo;    // algorithm enable
    logic        algRestart;   // one-cycle algorithm clear before a re-sweep
    logic        locked;       // high while the controller is locked
    logic        driveOut;     // NCO square-wave output

    modport master (
        output swiptAlive, freqAlgDone, newFreq, bestFreq,
        input  freq, freqAlgGo, algRestart, locked, driveOut
    );

    modport slave (
        input  swiptAlive, freqAlgDone, newFreq, bestFreq,
        output freq, freqAlgGo, algRestart, locked, driveOut
    );
endinterface

// File: rtl/freq_sweep_ctrl.sv
// Frequency sweep controller: runs the search algorithm, slews the NCO tuning word to its result, then holds lock.
// Latency: IDLE->SWEEP one clock after swiptAlive; freqAlgGo one clock later; slew one step per SLEW_DIV clocks.
// Backpressure: none; a low swiptAlive pre-empts every state and returns the block to IDLE on the next clock.
//
// Ports:
//   clk   - system clock, all state on its rising edge
//   nrst  - asynchronous active-low reset
//   sif   - freq_sweep_ctrl_if.slave: swiptAlive, freqAlgDone, newFreq, bestFreq in;
//           freq, freqAlgGo, algRestart, locked, driveOut out
//
// Optional feature: define FREQ_RESWEEP_EN to re-run the sweep after RESWEEP_PERIOD locked clocks.
// Without it algRestart is tied low and LOCKED is left only via swiptAlive=0 or reset.
module freq_sweep_ctrl #(
    parameter logic [19:0] INIT_FREQ      = 20'd100000,
    parameter logic [19:0] SLEW_STEP      = 20'd16,
    parameter logic [15:0] SLEW_DIV       = 16'd100,
    parameter logic [31:0] RESWEEP_PERIOD = 32'd50000000
) (
    input  logic             clk,
    input  logic             nrst,
    freq_sweep_ctrl_if.slave sif
);

    // A divider of 0 is treated as 1 so the tick counter never underflows.
    localparam logic [15:0] SLEW_RELOAD = (SLEW_DIV == 16'd0) ? 16'd0 : SLEW_DIV - 16'd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        APPLY  = 2'd2,
        LOCKED = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [19:0] freq_q;
    logic [19:0] freq_nxt;
    logic [19:0] target_q;
    logic [19:0] target_nxt;
    logic [19:0] diff;
    logic [15:0] slew_cnt;
    logic [23:0] phase_acc;
    logic        go_q;
    logic        done_q;
    logic        done_rise;
    logic        slew_tick;
    logic        hold_idle;

`ifdef FREQ_RESWEEP_EN
    localparam logic [31:0] RS_RELOAD = (RESWEEP_PERIOD == 32'd0) ? 32'd0 : RESWEEP_PERIOD - 32'd1;
    logic [31:0] rs_cnt;
    logic        restart_q;
`endif

    // done_q resets to 1 so a flag that is already high when the sweep starts
    // is not mistaken for a fresh completion; only a 0->1 transition counts.
    assign done_rise = sif.freqAlgDone & ~done_q;
    assign slew_tick = (slew_cnt == 16'd0);

    // The datapath is parked at its initial values both while sitting in IDLE
    // and on the clock that enters IDLE, so a link drop takes effect on the
    // very next clock rather than one clock later.
    assign hold_idle = (state == IDLE) || (state_nxt == IDLE);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   state_nxt = SWEEP;
            SWEEP:  if (done_rise) state_nxt = APPLY;
            // Equality is judged on the registered word, so LOCKED is entered
            // on the clock after the final slew step lands.
            APPLY:  if (freq_q == target_q) state_nxt = LOCKED;
            LOCKED: begin
`ifdef FREQ_RESWEEP_EN
                if (rs_cnt == 32'd0) state_nxt = SWEEP;
`endif
            end
            default: state_nxt = IDLE;
        endcase
        // Link loss overrides every other transition.
        if (!sif.swiptAlive) state_nxt = IDLE;
    end

    // ------------------------------------------------------------------
    // Target selection: follow the algorithm's trial word while sweeping,
    // capture its best result on completion, then hold.
    // ------------------------------------------------------------------
    always_comb begin
        target_nxt = target_q;
        if (hold_idle) begin
            target_nxt = INIT_FREQ;
        end else if (state == SWEEP) begin
            target_nxt = done_rise ? sif.bestFreq : sif.newFreq;
        end
    end

    // ------------------------------------------------------------------
    // Slew limiter: the magnitude is formed by ordering the operands first,
    // so the subtraction never wraps; a final partial step snaps exactly onto
    // the target, so the word never overshoots.
    // ------------------------------------------------------------------
    always_comb begin
        diff     = (target_q >= freq_q) ? (target_q - freq_q) : (freq_q - target_q);
        freq_nxt = freq_q;
        if (hold_idle) begin
            freq_nxt = INIT_FREQ;
        end else if (slew_tick) begin
            if (diff <= SLEW_STEP) begin
                freq_nxt = target_q;
            end else if (target_q > freq_q) begin
                freq_nxt = freq_q + SLEW_STEP;
            end else begin
                freq_nxt = freq_q - SLEW_STEP;
            end
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            freq_q    <= INIT_FREQ;
            target_q  <= INIT_FREQ;
            slew_cnt  <= SLEW_RELOAD;
            phase_acc <= 24'd0;
            go_q      <= 1'b0;
            done_q    <= 1'b1;
        end else begin
            state    <= state_nxt;
            freq_q   <= freq_nxt;
            target_q <= target_nxt;
            done_q   <= sif.freqAlgDone;

            // Enable is raised only once the controller has settled in SWEEP,
            // and dropped on the same clock that leaves it.
            go_q <= (state == SWEEP) && (state_nxt == SWEEP);

            if (hold_idle || slew_tick) begin
                slew_cnt <= SLEW_RELOAD;
            end else begin
                slew_cnt <= slew_cnt - 16'd1;
            end

            // NCO: the 20-bit word is zero-extended into a 24-bit accumulator
            // that wraps naturally; the MSB gives a 50% duty square wave.
            if (hold_idle) begin
                phase_acc <= 24'd0;
            end else begin
                phase_acc <= phase_acc + {4'b0000, freq_q};
            end
        end
    end

`ifdef FREQ_RESWEEP_EN
    // ------------------------------------------------------------------
    // Re-sweep timer: reloads whenever the controller is outside LOCKED,
    // so every lock entry starts a full period. The restart pulse is
    // issued on the same clock that re-enters SWEEP, one clock before
    // freqAlgGo rises, so the algorithm is cleared before it is enabled.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rs_cnt    <= RS_RELOAD;
            restart_q <= 1'b0;
        end else begin
            if (state != LOCKED) begin
                rs_cnt <= RS_RELOAD;
            end else if (rs_cnt != 32'd0) begin
                rs_cnt <= rs_cnt - 32'd1;
            end
            restart_q <= (state == LOCKED) && (state_nxt == SWEEP);
        end
    end

    assign sif.algRestart = restart_q;
`else
    assign sif.algRestart = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sif.freq      = freq_q;
    assign sif.freqAlgGo = go_q;
    assign sif.locked    = (state == LOCKED);
    assign sif.driveOut  = phase_acc[23];

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Self-checking bench for freq_sweep_ctrl with SLEW_DIV=1 and RESWEEP_PERIOD=10.
// Latency: n/a.
// Backpressure: n/a.
module tb_freq_sweep_ctrl;

    localparam logic [19:0] INIT = 20'd100000;

    logic clk  = 1'b0;
    logic nrst = 1'b0;

    int errors = 0;
    int checks = 0;

    // Scoreboard of expected tuning-word steps, popped on every freq change.
    logic [19:0] exp_q[$];
    logic [19:0] mon_exp;
    logic [19:0] mon_last = '0;
    logic        mon_en   = 1'b0;

    freq_sweep_ctrl_if ifc ();

    freq_sweep_ctrl #(
        .INIT_FREQ      (20'd100000),
        .SLEW_STEP      (20'd16),
        .SLEW_DIV       (16'd1),
        .RESWEEP_PERIOD (32'd10)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .sif  (ifc)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en && ifc.freq !== mon_last) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL slew_step: freq moved %0d -> %0d, no step expected", mon_last, ifc.freq);
            end else begin
                mon_exp = exp_q.pop_front();
                if (ifc.freq !== mon_exp) begin
                    errors++;
                    $display("FAIL slew_step: freq=%0d required %0d", ifc.freq, mon_exp);
                end
            end
        end
        mon_last = ifc.freq;
    end

    task automatic wait_freq(input logic [19:0] v, input int budget);
        int n = 0;
        while (ifc.freq !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        nrst = 1'b0;
        ifc.swiptAlive  = 1'b0;
        ifc.freqAlgDone = 1'b0;
        ifc.newFreq     = INIT;
        ifc.bestFreq    = INIT;
        repeat (3) @(negedge clk);
        checks++; if (ifc.freq !== INIT) begin errors++; $display("FAIL reset_freq: got %0d required %0d", ifc.freq, INIT); end
        checks++; if (ifc.freqAlgGo !== 1'b0) begin errors++; $display("FAIL reset_go: got %b required 0", ifc.freqAlgGo); end
        checks++; if (ifc.algRestart !== 1'b0) begin errors++; $display("FAIL reset_restart: got %b required 0", ifc.algRestart); end
        checks++; if (ifc.locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b required 0", ifc.locked); end
        checks++; if (ifc.driveOut !== 1'b0) begin errors++; $display("FAIL reset_drive: got %b required 0", ifc.driveOut); end
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (ifc.freqAlgGo !== 1'b0) begin errors++; $display("FAIL idle_hold_go: got %b required 0", ifc.freqAlgGo); end
    endtask

    task automatic test_startup;
        ifc.swiptAlive = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (ifc.freq !== INIT) begin errors++; $display("FAIL startup_freq: got %0d required %0d", ifc.freq, INIT); end
        checks++; if (ifc.freqAlgGo !== 1'b1) begin errors++; $display("FAIL startup_go: got %b required 1", ifc.freqAlgGo); end
    endtask

    task automatic test_sweep_slew;
        exp_q.delete();
        for (int v = 100016; v <= 100096; v += 16) exp_q.push_back(20'(v));
        exp_q.push_back(20'd100100);
        mon_en = 1'b1;
        ifc.newFreq = 20'd100100;
        wait_freq(20'd100100, 40);
        checks++; if (ifc.freq !== 20'd100100) begin errors++; $display("FAIL sweep_final: freq=%0d required 100100", ifc.freq); end
        repeat (5) @(negedge clk);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sweep_steps: %0d steps missing, required 0", exp_q.size()); end
        checks++; if (ifc.freqAlgGo !== 1'b1) begin errors++; $display("FAIL sweep_go: got %b required 1", ifc.freqAlgGo); end
    endtask

    task automatic test_done_apply;
        int v = 100100;
        while (v - 99980 > 16) begin
            v -= 16;
            exp_q.push_back(20'(v));
        end
        exp_q.push_back(20'd99980);
        ifc.bestFreq    = 20'd99980;
        ifc.freqAlgDone = 1'b1;
        @(negedge clk);
        checks++; if (ifc.freqAlgGo !== 1'b0) begin errors++; $display("FAIL done_go: got %b required 0", ifc.freqAlgGo); end
        wait_freq(20'd99980, 40);
        checks++; if (ifc.freq !== 20'd99980) begin errors++; $display("FAIL apply_final: freq=%0d required 99980", ifc.freq); end
        checks++; if (ifc.locked !== 1'b0) begin errors++; $display("FAIL apply_early_lock: got %b required 0", ifc.locked); end
        @(negedge clk);
        checks++; if (ifc.locked !== 1'b1) begin errors++; $display("FAIL apply_lock: got %b required 1", ifc.locked); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL apply_steps: %0d steps missing, required 0", exp_q.size()); end
        mon_en = 1'b0;
    endtask

    task automatic test_lock_behaviour;
`ifdef FREQ_RESWEEP_EN
        int n = 1;
        int guard = 0;
        while (ifc.algRestart !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (ifc.algRestart !== 1'b1 && ifc.locked === 1'b1) n++;
        end
        checks++; if (ifc.algRestart !== 1'b1) begin errors++; $display("FAIL resweep_pulse: algRestart=%b required 1 within 100 cycles", ifc.algRestart); end
        checks++; if (n != 10) begin errors++; $display("FAIL resweep_period: locked for %0d clocks required 10", n); end
        checks++; if (ifc.locked !== 1'b0) begin errors++; $display("FAIL resweep_unlock: got %b required 0", ifc.locked); end
        @(negedge clk);
        checks++; if (ifc.algRestart !== 1'b0) begin errors++; $display("FAIL resweep_single: algRestart=%b required 0", ifc.algRestart); end
        checks++; if (ifc.freqAlgGo !== 1'b1) begin errors++; $display("FAIL resweep_go: got %b required 1", ifc.freqAlgGo); end
`else
        int bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (ifc.locked !== 1'b1 || ifc.algRestart !== 1'b0 || ifc.freqAlgGo !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL lock_hold: %0d bad cycles required 0", bad); end
        checks++; if (ifc.freq !== 20'd99980) begin errors++; $display("FAIL lock_freq: got %0d required 99980", ifc.freq); end
`endif
    endtask

    task automatic test_done_level_ignored;
        int bad = 0;
        ifc.swiptAlive = 1'b0;
        @(negedge clk);
        ifc.freqAlgDone = 1'b1;
        ifc.newFreq     = INIT;
        ifc.bestFreq    = INIT;
        @(negedge clk);
        ifc.swiptAlive = 1'b1;
        repeat (2) @(negedge clk);
        repeat (20) begin
            @(negedge clk);
            if (ifc.freqAlgGo !== 1'b1 || ifc.locked !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL level_done: left SWEEP in %0d cycles, required 0", bad); end
        ifc.freqAlgDone = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ifc.freqAlgGo !== 1'b1) begin errors++; $display("FAIL level_done_low: go=%b required 1", ifc.freqAlgGo); end
        ifc.freqAlgDone = 1'b1;
        @(negedge clk);
        checks++; if (ifc.freqAlgGo !== 1'b0) begin errors++; $display("FAIL level_done_rise: go=%b required 0", ifc.freqAlgGo); end
        @(negedge clk);
        checks++; if (ifc.locked !== 1'b1) begin errors++; $display("FAIL level_done_lock: got %b required 1", ifc.locked); end
    endtask

    task automatic test_alive_drop;
        ifc.swiptAlive  = 1'b0;
        ifc.freqAlgDone = 1'b0;
        ifc.newFreq     = INIT;
        ifc.bestFreq    = 20'd200000;
        @(negedge clk);
        ifc.swiptAlive = 1'b1;
        repeat (5) @(negedge clk);
        ifc.freqAlgDone = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (ifc.freq !== 20'd100304) begin errors++; $display("FAIL drop_slewing: freq=%0d required 100304", ifc.freq); end
        ifc.swiptAlive = 1'b0;
        @(negedge clk);
        checks++; if (ifc.freq !== INIT) begin errors++; $display("FAIL drop_freq: got %0d required %0d", ifc.freq, INIT); end
        checks++; if (ifc.locked !== 1'b0) begin errors++; $display("FAIL drop_locked: got %b required 0", ifc.locked); end
        checks++; if (ifc.driveOut !== 1'b0) begin errors++; $display("FAIL drop_drive: got %b required 0", ifc.driveOut); end
        checks++; if (ifc.freqAlgGo !== 1'b0) begin errors++; $display("FAIL drop_go: got %b required 0", ifc.freqAlgGo); end
        repeat (5) @(negedge clk);
        checks++; if (ifc.freq !== INIT || ifc.freqAlgGo !== 1'b0) begin errors++; $display("FAIL drop_stay: freq=%0d go=%b required %0d/0", ifc.freq, ifc.freqAlgGo, INIT); end
    endtask

    // With freq fixed at 100000 the accumulator holds k*100000 after k adds;
    // bit 23 first sets at k=84 and wraps back low at k=168.
    task automatic test_nco;
        ifc.freqAlgDone = 1'b0;
        ifc.newFreq     = INIT;
        @(negedge clk);
        ifc.swiptAlive = 1'b1;
        repeat (84) @(negedge clk);
        checks++; if (ifc.driveOut !== 1'b0) begin errors++; $display("FAIL nco_k83: got %b required 0", ifc.driveOut); end
        @(negedge clk);
        checks++; if (ifc.driveOut !== 1'b1) begin errors++; $display("FAIL nco_k84: got %b required 1", ifc.driveOut); end
        repeat (83) @(negedge clk);
        checks++; if (ifc.driveOut !== 1'b1) begin errors++; $display("FAIL nco_k167: got %b required 1", ifc.driveOut); end
        @(negedge clk);
        checks++; if (ifc.driveOut !== 1'b0) begin errors++; $display("FAIL nco_wrap: got %b required 0", ifc.driveOut); end
    endtask

    task automatic test_reset_mid_slew;
        ifc.bestFreq    = 20'd300000;
        ifc.freqAlgDone = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (ifc.freq !== 20'd100144) begin errors++; $display("FAIL midslew_freq: got %0d required 100144", ifc.freq); end
        nrst = 1'b0;
        #1;
        checks++; if (ifc.freq !== INIT || ifc.freqAlgGo !== 1'b0 || ifc.locked !== 1'b0 || ifc.driveOut !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: freq=%0d go=%b locked=%b drive=%b required %0d/0/0/0", ifc.freq, ifc.freqAlgGo, ifc.locked, ifc.driveOut, INIT);
        end
        @(negedge clk);
        ifc.newFreq = INIT;
        nrst = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (ifc.freq !== INIT) begin errors++; $display("FAIL post_reset_freq: got %0d required %0d", ifc.freq, INIT); end
        checks++; if (ifc.freqAlgGo !== 1'b1 || ifc.locked !== 1'b0) begin errors++; $display("FAIL post_reset_sweep: go=%b locked=%b required 1/0", ifc.freqAlgGo, ifc.locked); end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_sweep_slew();
        test_done_apply();
        test_lock_behaviour();
        test_done_level_ignored();
        test_alive_drop();
        test_nco();
        test_reset_mid_slew();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/freq_sweep_ctrl.md
FREQ_SWEEP_CTRL -- requirements
Module: freq_sweep_ctrl

Interface
REQ-001 SHALL have parameter INIT_FREQ, default 20'd100000, tuning word applied after reset and in IDLE.
REQ-002 SHALL have parameter SLEW_STEP, default 20'd16, maximum freq change per slew tick.
REQ-003 SHALL have parameter SLEW_DIV, default 16'd100, clocks per slew tick (minimum 1).
REQ-004 SHALL have parameter RESWEEP_PERIOD, default 32'd50000000, LOCKED clocks before a re-sweep.
REQ-005 SHALL have port clk  in  1  single system clock; all state on its rising edge.
REQ-006 SHALL have port nrst  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port swiptAlive  in  1  link-up qualifier; low forces IDLE.
REQ-008 SHALL have port freqAlgDone  in  1  sweep-finished flag from the frequency algorithm.
REQ-009 SHALL have port newFreq  in  20  trial frequency requested by the algorithm.
REQ-010 SHALL have port bestFreq  in  20  best frequency found by the algorithm.
REQ-011 SHALL have port freq  out  20  currently applied tuning word, fed back to the algorithm.
REQ-012 SHALL have port freqAlgGo  out  1  enable to the algorithm.
REQ-013 SHALL have port algRestart  out  1  one-cycle pulse clearing the algorithm before a re-sweep.
REQ-014 SHALL have port locked  out  1  high while in LOCKED.
REQ-015 SHALL have port driveOut  out  1  NCO output, MSB of a 24-bit phase accumulator.

Function
REQ-016 SHALL implement FSM states IDLE, SWEEP, APPLY, LOCKED.
REQ-017 SHALL, in every state, synchronously force IDLE when swiptAlive=0; this overrides all other transitions.
REQ-018 SHALL, in IDLE: hold freq=INIT_FREQ, target=INIT_FREQ, go=0, locked=0; enter SWEEP on the first clock with swiptAlive=1.
REQ-019 SHALL, in SWEEP: assert freqAlgGo=1 and copy target<=newFreq every clock.
REQ-020 SHALL leave SWEEP only on a rising edge of freqAlgDone (registered previous value 0, current 1); a level-high done on SWEEP entry is ignored.
REQ-021 SHALL, on that edge: latch target<=bestFreq, drive freqAlgGo=0 from the next clock, enter APPLY.
REQ-022 SHALL, in APPLY: keep slewing; enter LOCKED on the clock after freq==target.
REQ-023 SHALL, in LOCKED: locked=1, freqAlgGo=0, freq constant.
REQ-024 SHALL slew with a tick counter reloaded to SLEW_DIV-1; on each tick (counter==0), if |target-freq|<=SLEW_STEP then freq<=target, else freq moves SLEW_STEP toward target.
REQ-025 SHALL compute the difference unsigned with an explicit compare, never wrap, and never overshoot target.
REQ-026 SHALL add {4'b0,freq} to a 24-bit phase accumulator every clock, wrapping modulo 2^24; driveOut = accumulator[23].
REQ-027 SHALL clear the phase accumulator in IDLE.

Reset
REQ-028 SHALL, while nrst=0 (asynchronously): state=IDLE, freq=INIT_FREQ, target=INIT_FREQ, freqAlgGo=0, algRestart=0, locked=0, driveOut=0, accumulator=0, slew and resweep counters reloaded, done-edge register=1.
REQ-029 SHALL resume in IDLE on the first clock after nrst deasserts; reset mid-slew discards target.

Configuration
REQ-030 SHALL honour macro FREQ_RESWEEP_EN.
REQ-031 SHALL, when FREQ_RESWEEP_EN is defined: count LOCKED clocks; after RESWEEP_PERIOD clocks pulse algRestart for one clock, then enter SWEEP; the counter reloads on every LOCKED entry.
REQ-032 SHALL, when FREQ_RESWEEP_EN is undefined: hold algRestart=0, omit the resweep counter, and stay in LOCKED until swiptAlive=0 or reset.

Verification
REQ-033 SHALL test: reset, then swiptAlive=1 -> freq=100000, freqAlgGo=1 on the second clock.
REQ-034 SHALL test: SWEEP with newFreq=100100, SLEW_DIV=1 -> freq steps 100016, 100032, ..., 100096, then 100100, with no overshoot.
REQ-035 SHALL test: freqAlgDone 0->1 with bestFreq=99980 -> freqAlgGo=0 next clock, freq slews down to 99980, locked=1 one clock after equality.
REQ-036 SHALL test: freqAlgDone already 1 on SWEEP entry -> remains in SWEEP until done falls and rises again.
REQ-037 SHALL test: swiptAlive drop during APPLY -> IDLE next clock, freq=100000, locked=0, driveOut=0.
REQ-038 SHALL test: FREQ_RESWEEP_EN defined, RESWEEP_PERIOD=10 -> algRestart single pulse after 10 LOCKED clocks, then freqAlgGo=1; with the macro undefined, locked stays 1 indefinitely.
